// File: rtl/cpu_nios_debug_pkg.sv
// ---------------------------------------------------------------------------
// cpu_nios_debug_pkg
// Shared types and constants for the Nios debug on-chip memory controller.
//   state_t  : controller states (IDLE, JRD, CRD)
//   jop_t    : pending JTAG operation type (RD / WR)
//   JDO_*    : bit positions of the fields packed into the 38-bit jdo word
// ---------------------------------------------------------------------------
package cpu_nios_debug_pkg;

    localparam int DATA_W = 32;

    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_RDEN_BIT  = 35;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        JRD  = 2'd1,
        CRD  = 2'd2
    } state_t;

    typedef enum logic {
        JOP_RD = 1'b0,
        JOP_WR = 1'b1
    } jop_t;

endpackage

// File: rtl/cpu_nios_debug_ram_sp.sv
// ---------------------------------------------------------------------------
// cpu_nios_debug_ram_sp
// Single-port synchronous RAM, 2^ADDR_W words of DATA_W bits, one-cycle read
// latency (read returns the contents before a same-cycle write). No reset:
// contents survive a controller reset.
// Ports:
//   clk      : clock
//   i_we     : write enable
//   i_addr   : word address
//   i_wdata  : write data
//   o_q      : registered read data for the address presented last cycle
// ---------------------------------------------------------------------------
module cpu_nios_debug_ram_sp
    import cpu_nios_debug_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_q
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_q <= r_mem[i_addr];
    end

    assign o_q = r_q;

endmodule

// File: rtl/cpu_nios_debug_ocimem.sv
// ---------------------------------------------------------------------------
// cpu_nios_debug_ocimem
// Debug on-chip memory controller. JTAG commands (jdo + ocimem strobes) read
// and write a private debug RAM through an auto-incrementing address
// register; the same RAM is shared with the CPU over an Avalon-MM slave.
// JTAG always has priority for the single RAM port.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   jdo                      : JTAG data word (address, read enable, wdata)
//   take_action_ocimem_a     : load address, optionally read
//   take_no_action_ocimem_a  : read at the current address
//   take_action_ocimem_b     : write at the current address
//   MonDReg                  : last JTAG read data
//   monitor_ready            : no JTAG operation in flight
//   monitor_error            : sticky, a JTAG command was dropped
//   avs_*                    : Avalon-MM slave port for the CPU
// ---------------------------------------------------------------------------
module cpu_nios_debug_ocimem
    import cpu_nios_debug_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_debugaccess,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_jpend;
    jop_t                r_jop;
    logic [DATA_W-1:0]   r_jwdata;
    logic [ADDR_W-1:0]   r_mon_a;
    logic [DATA_W-1:0]   r_mon_d;
    logic                r_mon_err;
    logic [DATA_W-1:0]   r_avs_rdata;

    logic                w_busy;
    logic                w_any_strobe;
    logic                w_new_jop;
    logic                w_jtag_go;
    logic                w_ram_we;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]   w_ram_wdata;
    logic [DATA_W-1:0]   w_ram_q;
    logic                w_unused_jdo;

    assign w_unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign w_busy       = r_jpend | (r_state == JRD);
    assign w_any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    // A strobe this cycle that will create a RAM operation (address-only
    // loads do not touch the RAM).
    assign w_new_jop    = take_no_action_ocimem_b_or_read();
    assign w_jtag_go    = (r_state == IDLE) & r_jpend;

    function automatic logic take_no_action_ocimem_b_or_read();
        return take_no_action_ocimem_a | take_action_ocimem_b
             | (take_action_ocimem_a & jdo[JDO_RDEN_BIT]);
    endfunction

    // Next-state and RAM port arbitration
    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_mon_a;
        w_ram_wdata = r_jwdata;
        case (r_state)
            IDLE: begin
                if (r_jpend) begin
                    w_ram_we = (r_jop == JOP_WR);
                    if (r_jop == JOP_RD) begin
                        w_state_nxt = JRD;
                    end
                end else if (avs_write) begin
                    w_ram_addr  = avs_address;
                    w_ram_wdata = avs_writedata;
                    w_ram_we    = avs_debugaccess;
                end else if (avs_read && !w_new_jop) begin
                    // A JTAG command arriving this cycle claims the port
                    // first; the CPU read stays stalled in IDLE.
                    w_ram_addr  = avs_address;
                    w_state_nxt = CRD;
                end
            end
            JRD:     w_state_nxt = IDLE;
            CRD:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_jpend     <= 1'b0;
            r_jop       <= JOP_RD;
            r_mon_a     <= '0;
            r_mon_d     <= '0;
            r_mon_err   <= 1'b0;
            r_avs_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_jtag_go) begin
                r_jpend <= 1'b0;
                r_mon_a <= r_mon_a + 1'b1;
            end

            // w_jtag_go implies busy, so it never collides with an
            // accepted strobe below.
            if (w_any_strobe) begin
                if (w_busy) begin
                    r_mon_err <= 1'b1;
                end else if (take_action_ocimem_a) begin
                    r_mon_a   <= jdo[JDO_ADDR_LSB +: ADDR_W];
                    r_mon_err <= 1'b0;
                    if (jdo[JDO_RDEN_BIT]) begin
                        r_jpend <= 1'b1;
                        r_jop   <= JOP_RD;
                    end
                end else if (take_no_action_ocimem_a) begin
                    r_jpend <= 1'b1;
                    r_jop   <= JOP_RD;
                end else begin
                    r_jpend <= 1'b1;
                    r_jop   <= JOP_WR;
                end
            end

            if (r_state == JRD) begin
                r_mon_d <= w_ram_q;
            end
            if (r_state == CRD) begin
                r_avs_rdata <= w_ram_q;
            end
        end
    end

    // Write data is only meaningful while a WR is pending; no reset needed.
    always_ff @(posedge clk) begin
        if (take_action_ocimem_b && !w_busy) begin
            r_jwdata <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
        end
    end

    cpu_nios_debug_ram_sp #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_q     (w_ram_q)
    );

    assign MonDReg       = r_mon_d;
    assign monitor_ready = !w_busy;
    assign monitor_error = r_mon_err;
    // Data is presented live in CRD (the non-stalled cycle) and held after.
    assign avs_readdata  = (r_state == CRD) ? w_ram_q : r_avs_rdata;
    assign avs_waitrequest = (avs_read | avs_write)
                           & !((r_state == IDLE) & !r_jpend & avs_write)
                           & !(r_state == CRD);

endmodule

// File: tb/tb_cpu_nios_debug_ocimem.sv
module tb_cpu_nios_debug_ocimem;

    localparam int AW = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic [37:0]   jdo;
    logic          take_action_ocimem_a;
    logic          take_no_action_ocimem_a;
    logic          take_action_ocimem_b;
    logic [31:0]   MonDReg;
    logic          monitor_ready;
    logic          monitor_error;
    logic [AW-1:0] avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic          avs_debugaccess;
    logic [31:0]   avs_readdata;
    logic          avs_waitrequest;

    cpu_nios_debug_ocimem #(.ADDR_W(AW)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_debugaccess         (avs_debugaccess),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest)
    );

    always #5 clk = ~clk;

    // Reference model: memory image, which words are known, JTAG address.
    logic [31:0] mdl [DEPTH];
    bit          known [DEPTH];
    int          maddr;
    int          n_cmp;
    int          n_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] jdo_addr(input int a, input logic rd);
        logic [37:0] j;
        j = '0;
        j[24:17] = a[7:0];
        j[35] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_wr(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // k: 0 = action_a, 1 = no_action_a, 2 = action_b. Ends at the negedge
    // after the edge that sampled the strobe.
    task automatic strobe(input int k, input logic [37:0] d);
        @(negedge clk);
        jdo = d;
        take_action_ocimem_a    = (k == 0);
        take_no_action_ocimem_a = (k == 1);
        take_action_ocimem_b    = (k == 2);
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!monitor_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, monitor_ready}, 32'd1);
    endtask

    task automatic jtag_rd_check(input string tag);
        wait_ready({tag, "_rdy"});
        if (known[maddr]) chk(tag, MonDReg, mdl[maddr]);
        maddr = (maddr + 1) % DEPTH;
    endtask

    task automatic jtag_load(input int a, input logic rd, input string tag);
        strobe(0, jdo_addr(a, rd));
        maddr = a % DEPTH;
        if (rd) jtag_rd_check(tag);
    endtask

    task automatic jtag_write(input logic [31:0] d, input string tag);
        strobe(2, jdo_wr(d));
        wait_ready(tag);
        mdl[maddr] = d;
        known[maddr] = 1'b1;
        maddr = (maddr + 1) % DEPTH;
    endtask

    task automatic jtag_next(input string tag);
        strobe(1, '0);
        jtag_rd_check(tag);
    endtask

    task automatic cpu_write(input int a, input logic [31:0] d, input logic dbg, input string tag);
        int n;
        @(negedge clk);
        avs_address = a[AW-1:0];
        avs_writedata = d;
        avs_debugaccess = dbg;
        avs_write = 1'b1;
        #1;
        n = 0;
        while (avs_waitrequest && n < 16) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, {31'b0, avs_waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        avs_debugaccess = 1'b0;
        if (dbg) begin
            mdl[a] = d;
            known[a] = 1'b1;
        end
    endtask

    task automatic cpu_read(input int a, input string tag);
        int n;
        @(negedge clk);
        avs_address = a[AW-1:0];
        avs_read = 1'b1;
        #1;
        n = 0;
        while (avs_waitrequest && n < 16) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_wait"}, {31'b0, avs_waitrequest}, 32'd0);
        if (known[a]) chk(tag, avs_readdata, mdl[a]);
        @(posedge clk);
        #1;
        avs_read = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] d1;
        logic [31:0] d2;
        n_cmp = 0;
        n_mis = 0;
        maddr = 0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_debugaccess = 1'b0;

        // Reset state
        #1;
        chk("rst_mondreg", MonDReg, 32'd0);
        chk("rst_ready", {31'b0, monitor_ready}, 32'd1);
        chk("rst_error", {31'b0, monitor_error}, 32'd0);
        chk("rst_avs_rdata", avs_readdata, 32'd0);
        chk("rst_waitreq", {31'b0, avs_waitrequest}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Address load and read with exact latency
        jtag_load(5, 1'b0, "ld5");
        jtag_write(32'hDEADBEEF, "wr5");
        strobe(0, jdo_addr(5, 1'b1));
        chk("rd5_busy_e0", {31'b0, monitor_ready}, 32'd0);
        @(negedge clk);
        chk("rd5_busy_e1", {31'b0, monitor_ready}, 32'd0);
        @(negedge clk);
        chk("rd5_ready_e2", {31'b0, monitor_ready}, 32'd1);
        chk("rd5_data", MonDReg, 32'hDEADBEEF);
        chk("rd5_addr_inc", {24'b0, dut.r_mon_a}, 32'd6);
        maddr = 6;

        // Burst and wrap-around
        d1 = $urandom;
        d2 = $urandom;
        jtag_load(255, 1'b0, "ld255");
        jtag_write(d1, "wr255");
        jtag_write(d2, "wr0");
        chk("wrap_addr", {24'b0, dut.r_mon_a}, 32'd1);
        cpu_read(255, "cpu_rd255");
        cpu_read(0, "cpu_rd0");
        jtag_load(255, 1'b1, "jrd255");
        jtag_next("jrd0");

        // Collision: second read strobe one cycle after the first
        jtag_load(40, 1'b0, "ld40");
        jtag_write($urandom, "wr40");
        jtag_write($urandom, "wr41");
        @(negedge clk);
        jdo = jdo_addr(40, 1'b1);
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        chk("coll_error", {31'b0, monitor_error}, 32'd1);
        maddr = 40;
        jtag_rd_check("coll_rd40");
        jtag_next("coll_one_read_41");
        chk("coll_error_sticky", {31'b0, monitor_error}, 32'd1);
        jtag_load(40, 1'b0, "ld40b");
        chk("coll_error_clr", {31'b0, monitor_error}, 32'd0);

        // Arbitration: CPU read and JTAG write to addr 3 in the same cycle
        jtag_load(3, 1'b0, "ld3");
        jtag_write(32'h0BADF00D, "wr3_old");
        jtag_load(3, 1'b0, "ld3b");
        @(negedge clk);
        jdo = jdo_wr(32'h12345678);
        take_action_ocimem_b = 1'b1;
        avs_address = 8'd3;
        avs_read = 1'b1;
        #1;
        chk("arb_wait_e0", {31'b0, avs_waitrequest}, 32'd1);
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        #1;
        chk("arb_wait_e1", {31'b0, avs_waitrequest}, 32'd1);
        n = 0;
        while (avs_waitrequest && n < 16) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("arb_wait_done", {31'b0, avs_waitrequest}, 32'd0);
        chk("arb_data", avs_readdata, 32'h12345678);
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        mdl[3] = 32'h12345678;
        known[3] = 1'b1;
        maddr = 4;

        // Debugaccess gating
        jtag_load(9, 1'b0, "ld9");
        jtag_write(32'h11112222, "wr9_old");
        cpu_write(9, 32'hA5A5A5A5, 1'b0, "cpu_wr9_nodbg");
        jtag_load(9, 1'b1, "dbg0_rd9");
        chk("dbg0_old", MonDReg, 32'h11112222);
        cpu_write(9, 32'hA5A5A5A5, 1'b1, "cpu_wr9_dbg");
        jtag_load(9, 1'b1, "dbg1_rd9");
        chk("dbg1_new", MonDReg, 32'hA5A5A5A5);

        // Randomized mixed traffic against the model
        for (int it = 0; it < 60; it++) begin
            int op;
            int a;
            op = $urandom_range(0, 4);
            a = $urandom_range(0, DEPTH - 1);
            case (op)
                0: jtag_load(a, 1'($urandom_range(0, 1)), "rnd_jload");
                1: jtag_write($urandom, "rnd_jwr");
                2: jtag_next("rnd_jnext");
                3: cpu_write(a, $urandom, 1'($urandom_range(0, 1)), "rnd_cwr");
                default: cpu_read(a, "rnd_crd");
            endcase
        end

        // Reset during JRD
        jtag_load(9, 1'b1, "pre_rst_rd");
        strobe(0, jdo_addr(9, 1'b1));
        @(negedge clk);
        chk("rst_in_jrd", {31'b0, monitor_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_mid_mondreg", MonDReg, 32'd0);
        chk("rst_mid_ready", {31'b0, monitor_ready}, 32'd1);
        chk("rst_mid_addr", {24'b0, dut.r_mon_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        maddr = 0;
        @(negedge clk);
        chk("rst_hold_mondreg", MonDReg, 32'd0);
        jtag_next("post_rst_rd0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
